gather_16: RTL and testbench

Serial-to-parallel operand gatherer that produces the 16 signed operands consumed by the 16-input adder tree. It accepts one `w1`-bit partial product per beat over a valid/ready stream, assembles 16 consecutive beats into a group, and presents the group in parallel with its own valid/ready handshake. It sits between the per-channel MAC/partial-product stage and the 16-way summation stage of the convolution datapath.

---
 rtl/gather_pkg.sv | 14 +
 rtl/gather_bank.sv | 28 ++
 rtl/gather_16.sv | 127 ++++++++++++
 tb/tb_gather_16.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gather_pkg.sv
// Shared constants and types for the 16-lane operand gatherer.
// The GATHER16_PINGPONG_EN build uses bank_sel_t to address lane banks A/B.
package gather_pkg;
  localparam int LANES = 16;
  localparam int CNT_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // 0 selects bank A, 1 selects bank B
  typedef logic bank_sel_t;
endpackage

// File: rtl/gather_bank.sv
// One bank of 16 lane registers, written one lane at a time and read as a flat bus.
module gather_bank
  import gather_pkg::*;
#(
  parameter int w1 = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [CNT_W-1:0]      idx,
  input  logic [w1-1:0]         data,
  output logic [LANES*w1-1:0]   bus
);
  logic [w1-1:0] lane_q [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (we) begin
      lane_q[idx] <= data;
    end
  end

  always_comb begin
    bus = '0;
    for (int k = 0; k < LANES; k++) bus[k*w1 +: w1] = lane_q[k];
  end
endmodule

// File: rtl/gather_16.sv
// Serial-to-parallel gatherer: 16 accepted beats become one parallel group.
// Define GATHER16_PINGPONG_EN for a two-bank build that fills one bank while the other is held.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid is never
// withdrawn before the transfer and the payload is stable while valid is high.
module gather_16
  import gather_pkg::*;
#(
  parameter int w1 = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [w1-1:0]         in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*w1-1:0]   out_bus,
  output logic                  err
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             err_q;
  logic             accept;
  logic             early;
  logic             complete;
  logic             wr_en;
  logic             consume;

  assign accept   = in_valid && in_ready_q;
  assign early    = accept && in_last && (cnt_q != LAST_IDX);
  assign complete = accept && (cnt_q == LAST_IDX);
  // An early-last beat is dropped along with the rest of its partial group.
  assign wr_en    = accept && !early;
  assign consume  = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= early || (complete && !in_last);
      if (early || complete) cnt_q <= '0;
      else if (accept)       cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef GATHER16_PINGPONG_EN
  bank_sel_t             wr_sel_q;
  bank_sel_t             rd_sel_q;
  bank_sel_t             rd_sel_d;
  logic [1:0]            full_q;
  logic [1:0]            full_d;
  logic [LANES*w1-1:0]   bus_a;
  logic [LANES*w1-1:0]   bus_b;

  always_comb begin
    full_d = full_q;
    if (consume)  full_d[rd_sel_q] = 1'b0;
    if (complete) full_d[wr_sel_q] = 1'b1;
    rd_sel_d = consume ? ~rd_sel_q : rd_sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      rd_sel_q    <= rd_sel_d;
      if (complete) wr_sel_q <= ~wr_sel_q;
      out_valid_q <= full_d[rd_sel_d];
      in_ready_q  <= !(&full_d);
    end
  end

  gather_bank #(.w1(w1)) u_bank_a (
    .clk(clk), .rst_n(rst_n), .we(wr_en && (wr_sel_q == 1'b0)),
    .idx(cnt_q), .data(in_data), .bus(bus_a)
  );
  gather_bank #(.w1(w1)) u_bank_b (
    .clk(clk), .rst_n(rst_n), .we(wr_en && (wr_sel_q == 1'b1)),
    .idx(cnt_q), .data(in_data), .bus(bus_b)
  );

  assign out_bus = rd_sel_q ? bus_b : bus_a;
`else
  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (complete) state_d = HOLD;
      HOLD:    if (consume)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == HOLD);
      in_ready_q  <= (state_d == FILL);
    end
  end

  gather_bank #(.w1(w1)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(wr_en),
    .idx(cnt_q), .data(in_data), .bus(out_bus)
  );
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
endmodule

// File: tb/tb_gather_16.sv
// Bench for gather_16 (default single-bank build): table of groups plus hand-written corner sequences.
module tb_gather_16;
  localparam int W  = 21;
  localparam int BW = 16 * W;

  typedef logic [W-1:0] lanes_t [16];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           alt;
    bit           last_ok;
    int           gap_at;
    int           stall;
    bit           rdy_early;
    longint       exp_sum;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_bus;
  logic          err;

  logic [BW-1:0] exp_q[$];
  int            checks;
  int            failures;
  vec_t          vt [5];

  gather_16 #(.w1(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus), .err(err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input lanes_t l);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*W +: W] = l[k];
    return r;
  endfunction

  function automatic longint bus_sum(input logic [BW-1:0] b);
    longint s;
    s = 0;
    for (int k = 0; k < 16; k++) s += longint'($signed(b[k*W +: W]));
    return s;
  endfunction

  // driver: one beat per cycle, optional idle cycle before beat gap_at
  task automatic send_group(input lanes_t l, input bit last_ok, input int gap_at);
    exp_q.push_back(pack(l));
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_out_valid", out_valid, 0);
      end
      chk("beat_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = l[k];
      in_last  = (k == 15) ? last_ok : 1'b0;
      @(posedge clk); #1;
      chk("beat_err", err, (k == 15 && !last_ok) ? 1 : 0);
      chk("beat_out_valid", out_valid, (k == 15) ? 1 : 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // scoreboard side: hold off out_ready for stall cycles, then take the group
  task automatic drain(input int stall, input longint exp_sum);
    logic [BW-1:0] exp;
    int            wait_n;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    wait_n = 0;
    while (!out_valid && wait_n < 5) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk("out_valid_timeout", out_valid, 1);
    for (int c = 0; c < stall; c++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk_bus("bp_out_bus", out_bus, exp);
      @(posedge clk); #1;
    end
    chk_bus("group_bus", out_bus, exp);
    chk("group_sum", bus_sum(out_bus), exp_sum);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk_bus({tag, "_out_bus"}, out_bus, '0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", in_ready, 1);
  endtask

  initial begin
    lanes_t l;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    //        a             b             alt last gap stall rdy  sum
    vt[0] = '{21'd1,       21'd1,        0,  1,  -1,  0,   1,   136};
    vt[1] = '{21'h1FFFFF,  21'h0FFFFF,   1,  1,  -1,  0,   1,   8388592};
    vt[2] = '{21'h100000,  21'd0,        0,  1,   7,  3,   0,   -16777216};
    vt[3] = '{21'h1FFFF8,  21'd1,        0,  0,  -1, 10,   0,   -8};
    vt[4] = '{21'd100,     21'h1FFFF3,   0,  1,  15,  1,   0,   40};

    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    release_reset();

    foreach (vt[i]) begin
      for (int k = 0; k < 16; k++)
        l[k] = vt[i].alt ? ((k % 2 == 0) ? vt[i].a : vt[i].b) : vt[i].a + W'(k) * vt[i].b;
      out_ready = vt[i].rdy_early;
      send_group(l, vt[i].last_ok, vt[i].gap_at);
      drain(vt[i].stall, vt[i].exp_sum);
    end

    // early last on beat 5 drops the partial group
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = W'(50 + k);
      in_last  = (k == 4);
      @(posedge clk); #1;
      chk("early_err", err, (k == 4) ? 1 : 0);
      chk("early_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk); #1;
    chk("early_err_cleared", err, 0);
    chk("early_no_out_valid", out_valid, 0);
    for (int k = 0; k < 16; k++) l[k] = W'(200 + k);
    send_group(l, 1'b1, -1);
    drain(0, 3320);

    // reset after 9 beats
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom_range(0, (1 << W) - 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midgroup");
    release_reset();
    for (int k = 0; k < 16; k++) l[k] = W'($urandom_range(0, (1 << W) - 1));
    send_group(l, 1'b1, -1);
    drain(2, bus_sum(pack(l)));

    // reset while a complete group is held
    for (int k = 0; k < 16; k++) l[k] = W'(k + 1000);
    send_group(l, 1'b1, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midhold");
    void'(exp_q.pop_front());
    release_reset();
    for (int k = 0; k < 16; k++) l[k] = W'(16 - k);
    send_group(l, 1'b1, 3);
    drain(0, 136);

    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
